lane_burst_scheduler: RTL
=========================

Name: lane_burst_scheduler

Overview:
- Sequences 128-bit parallel sample words (8 lanes x 16 bits; lane k = bits [16k+15:16k]) onto a single 16-bit lane stream.
- Emits only the lanes selected by a mask, lowest lane first, for a programmed burst of words.
- Sits between the wide ADC/DDS sample path and narrow consumers (capture FIFO, DMA packer). Provides start/busy/done control to the processor-side register block.

Parameters:
- LANES, 8, number of lanes per word (power of 2)
- LANE_WIDTH, 16, bits per lane
- COUNT_WIDTH, 16, width of burst word counter

Ports:
- clock  in  1  system clock; all logic rising-edge
- resetn  in  1  asynchronous active-low reset
- start  in  1  one-cycle pulse; begins a burst; ignored while busy=1
- word_count  in  COUNT_WIDTH  words in burst; sampled on accepted start
- lane_mask  in  LANES  lanes to emit (bit k = lane k); sampled on accepted start
- busy  out  1  high from the cycle after accepted start until done
- done  out  1  one-cycle pulse at burst end or on rejected start
- cfg_error  out  1  one-cycle pulse with done when start is rejected
- in_data  in  LANES*LANE_WIDTH  parallel sample word
- in_valid  in  1  in_data valid
- in_ready  out  1  word accepted when in_valid & in_ready
- out_data  out  LANE_WIDTH  selected lane sample
- out_lane  out  log2(LANES)  index of lane on out_data
- out_last  out  1  final lane of final word of burst
- out_valid  out  1  out_data valid
- out_ready  in  1  downstream accepts when out_valid & out_ready

Behaviour:
- Reset (async assert, sync deassert): state IDLE. busy, done, cfg_error, in_ready, out_valid, out_last = 0; out_data, out_lane = 0. Holding register empty; counters = 0.
- States: IDLE, RUN.
- IDLE, start=1:
  - word_count==0 or lane_mask==0: stay IDLE; next cycle done=1, cfg_error=1.
  - Otherwise: latch word_count and lane_mask, clear words_in and words_out, go RUN; busy=1 next cycle.
- RUN, input side:
  - in_ready = (words_in < word_count) & (hold empty | (out_valid & out_ready & current lane is last remaining lane of held word)).
  - Back-to-back words are supported with no bubble.
  - On accept: hold <= in_data, remaining <= latched mask, words_in++.
- RUN, output side:
  - out_valid = hold full.
  - out_lane = index of lowest set bit of remaining; out_data = hold lane[out_lane].
  - out_data and out_lane are stable while out_valid & ~out_ready.
  - On handshake: clear that remaining bit. If remaining becomes 0: words_out++, and hold empties unless refilled the same cycle.
  - out_last = 1 when words_out == word_count-1 and exactly one remaining bit is set.
- Latency: word accepted in cycle N -> first lane out_valid in cycle N+1. Throughput is one lane per cycle with out_ready held high.
- Completion: the handshake with out_last=1 moves state to IDLE next cycle. done=1 for that one cycle; busy=0 and in_ready=0 from the same cycle.
- start during RUN: ignored; no done or cfg_error pulse.
- Input side is never back-pressured by cfg changes: lane_mask and word_count changes during RUN have no effect.
- word_count = 2^COUNT_WIDTH-1 is legal; counters must not wrap before the compare.
- Async reset mid-burst: all state discarded immediately; no done pulse; a partially emitted word is lost.

Test Plan:
- Full mask, word_count=2, in_data words W0 = lanes 0x0000..0x0007, W1 = lanes 0x0100..0x0107, out_ready=1 -> 16 beats, lanes 0..7 twice, data 0x0000..0x0007 then 0x0100..0x0107, no gaps. out_last only on beat 16; done 1 cycle after; busy drops.
- lane_mask=0x81, word_count=3 -> 6 beats, out_lane sequence 0,7,0,7,0,7; in_ready high only while words_in<3.
- Back-pressure: mask 0xFF, toggle out_ready 1/0 every cycle -> out_data/out_lane stable while stalled; exactly 8 beats per word; no word accepted before the previous word's last lane handshake.
- Rejected start: start with word_count=0 (mask 0xFF), then start with mask=0x00 (count 5) -> each gives done=1, cfg_error=1 for one cycle; busy stays 0; in_ready stays 0.
- start pulse during RUN with different mask -> ignored; the burst completes with the original mask and count.
- Assert resetn=0 after 3 beats of a 2-word burst -> outputs zero immediately; after release, a new start with mask 0x04, count 1 yields a single beat lane 2 with out_last=1.

Source files
------------

// File: rtl/lane_burst_scheduler_if.sv
`default_nettype none
`timescale 1ns/1ps
// +----------------------------------------------------------------------------+
// | lane_burst_scheduler_if                                                    |
// | Control, wide sample input and narrow lane output bundle of the scheduler. |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
interface lane_burst_scheduler_if #(
  parameter int LANES       = 8,
  parameter int LANE_WIDTH  = 16,
  parameter int COUNT_WIDTH = 16
);
  logic                          start;
  logic [COUNT_WIDTH-1:0]        word_count;
  logic [LANES-1:0]              lane_mask;
  logic                          busy;
  logic                          done;
  logic                          cfg_error;
  logic [LANES*LANE_WIDTH-1:0]   in_data;
  logic                          in_valid;
  logic                          in_ready;
  logic [LANE_WIDTH-1:0]         out_data;
  logic [$clog2(LANES)-1:0]      out_lane;
  logic                          out_last;
  logic                          out_valid;
  logic                          out_ready;

  modport slave (
    input  start, word_count, lane_mask, in_data, in_valid, out_ready,
    output busy, done, cfg_error, in_ready, out_data, out_lane, out_last, out_valid
  );

  modport master (
    output start, word_count, lane_mask, in_data, in_valid, out_ready,
    input  busy, done, cfg_error, in_ready, out_data, out_lane, out_last, out_valid
  );
endinterface
`default_nettype wire

// File: rtl/lane_burst_scheduler.sv
`default_nettype none
`timescale 1ns/1ps
// +----------------------------------------------------------------------------+
// | lane_burst_scheduler                                                       |
// | Serialises mask-selected lanes of wide sample words, lowest lane first,    |
// | for a programmed burst of words.                                           |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module lane_burst_scheduler #(
  parameter int LANES       = 8,
  parameter int LANE_WIDTH  = 16,
  parameter int COUNT_WIDTH = 16
) (
  input  wire logic             clock,
  input  wire logic             resetn,
  lane_burst_scheduler_if.slave bus
);

  localparam int                     c_lane_idx_w = $clog2(LANES);
  localparam logic [LANES-1:0]       c_lane_one   = {{(LANES-1){1'b0}}, 1'b1};
  localparam logic [COUNT_WIDTH-1:0] c_cnt_one    = {{(COUNT_WIDTH-1){1'b0}}, 1'b1};

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  state_t                       r_state;
  state_t                       w_state_nxt;

  logic [COUNT_WIDTH-1:0]       r_count;
  logic [COUNT_WIDTH-1:0]       r_words_in;
  logic [COUNT_WIDTH-1:0]       r_words_out;
  logic [LANES-1:0]             r_mask;
  logic [LANES-1:0]             r_remaining;
  logic [LANES*LANE_WIDTH-1:0]  r_hold;
  logic                         r_hold_full;
  logic                         r_done;
  logic                         r_cfg_error;

  logic                         w_start_ok;
  logic                         w_start_bad;
  logic [LANES-1:0]             w_lowbit;
  logic                         w_one_left;
  logic [c_lane_idx_w-1:0]      w_lane;
  logic [LANE_WIDTH-1:0]        w_lanes [LANES];
  logic                         w_out_fire;
  logic                         w_word_drain;
  logic                         w_more_in;
  logic                         w_in_ready;
  logic                         w_in_fire;
  logic                         w_last;
  logic                         w_finish;

  assign w_start_ok  = (r_state == S_IDLE) && bus.start &&
                       (bus.word_count != '0) && (bus.lane_mask != '0);
  assign w_start_bad = (r_state == S_IDLE) && bus.start &&
                       ((bus.word_count == '0) || (bus.lane_mask == '0));

  // Two's-complement trick isolates the lowest pending lane.
  assign w_lowbit   = r_remaining & (~r_remaining + c_lane_one);
  assign w_one_left = (r_remaining != '0) && ((r_remaining & (r_remaining - c_lane_one)) == '0);

  always_comb begin
    w_lane = '0;
    for (int k = LANES - 1; k >= 0; k--) begin
      if (r_remaining[k]) begin
        w_lane = c_lane_idx_w'(k);
      end
    end
  end

  for (genvar g = 0; g < LANES; g++) begin : g_lanes
    assign w_lanes[g] = r_hold[g*LANE_WIDTH +: LANE_WIDTH];
  end

  assign w_out_fire   = r_hold_full && bus.out_ready;
  assign w_word_drain = w_out_fire && w_one_left;
  assign w_more_in    = (r_words_in < r_count);
  // A new word may land in the same cycle the held word's last lane leaves.
  assign w_in_ready   = (r_state == S_RUN) && w_more_in && (!r_hold_full || w_word_drain);
  assign w_in_fire    = w_in_ready && bus.in_valid;
  assign w_last       = r_hold_full && w_one_left && (r_words_out == (r_count - c_cnt_one));
  assign w_finish     = w_out_fire && w_last;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_start_ok) w_state_nxt = S_RUN;
      S_RUN:   if (w_finish)   w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_count     <= '0;
      r_words_in  <= '0;
      r_words_out <= '0;
      r_mask      <= '0;
      r_remaining <= '0;
      r_hold      <= '0;
      r_hold_full <= 1'b0;
      r_done      <= 1'b0;
      r_cfg_error <= 1'b0;
    end else begin
      r_done      <= w_finish || w_start_bad;
      r_cfg_error <= w_start_bad;
      if (w_start_ok) begin
        r_count     <= bus.word_count;
        r_mask      <= bus.lane_mask;
        r_words_in  <= '0;
        r_words_out <= '0;
        r_remaining <= '0;
        r_hold_full <= 1'b0;
      end else begin
        if (w_out_fire) begin
          r_remaining <= r_remaining & ~w_lowbit;
          if (w_one_left) begin
            r_words_out <= r_words_out + c_cnt_one;
            r_hold_full <= 1'b0;
          end
        end
        // Refill takes priority over the drain above.
        if (w_in_fire) begin
          r_hold      <= bus.in_data;
          r_remaining <= r_mask;
          r_words_in  <= r_words_in + c_cnt_one;
          r_hold_full <= 1'b1;
        end
      end
    end
  end

  assign bus.busy      = (r_state == S_RUN);
  assign bus.done      = r_done;
  assign bus.cfg_error = r_cfg_error;
  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = r_hold_full;
  assign bus.out_lane  = w_lane;
  assign bus.out_data  = w_lanes[w_lane];
  assign bus.out_last  = w_last;

endmodule
`default_nettype wire
